// File: rtl/slot_reel_controller.sv
// Purpose: spins NUM_REELS symbol counters, halts them staggered after STOP, flags win/lose.
// Latency: reels_stopped 16 edges after STOP entry, win/lose flag one edge later (defaults).
// Backpressure: none; follows the sampled game-state code every cycle.
module slot_reel_controller #(
   parameter int NUM_REELS = 3,
   parameter int SYMBOL_W  = 3,
   parameter int SPIN_DIV  = 4,
   parameter int STAGGER   = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [1:0]                    state,
   output logic [NUM_REELS*SYMBOL_W-1:0] reel_val,
   output logic                          reels_stopped,
   output logic                          win_flag,
   output logic                          lose_flag
);

   localparam logic [1:0] G_SET  = 2'b00;
   localparam logic [1:0] G_RUN  = 2'b01;
   localparam logic [1:0] G_STOP = 2'b10;
   localparam logic [1:0] G_WIN  = 2'b11;

   // Divider must hold the largest terminal count SPIN_DIV+NUM_REELS-2.
   localparam int DIV_W  = $clog2(SPIN_DIV + NUM_REELS);
   // Stop counter must hold the last-reel freeze point STAGGER*(NUM_REELS-1).
   localparam int LAST   = STAGGER * (NUM_REELS - 1);
   localparam int SC_W   = $clog2(LAST + 2);

   typedef enum logic [2:0] {S_IDLE, S_SPIN, S_HALT, S_EVAL, S_DONE} fsm_t;

   fsm_t                fsm_q, fsm_d;
   logic [SYMBOL_W-1:0] reel_q    [NUM_REELS];
   logic [SYMBOL_W-1:0] reel_d    [NUM_REELS];
   logic [DIV_W-1:0]    div_cnt_q [NUM_REELS];
   logic [DIV_W-1:0]    div_cnt_d [NUM_REELS];
   logic [SC_W-1:0]     stop_cnt_q, stop_cnt_d;
   logic                stopped_q, stopped_d;
   logic                win_q, win_d;
   logic                lose_q, lose_d;

   // Control strobes decoded from FSM state and sampled game state.
   logic                stop_in;
   logic                spin_all;
   logic                halt_edge;
   logic                restart;
   logic [SC_W-1:0]     halt_idx;

   // WIN is sequenced exactly like STOP while reels are still moving.
   assign stop_in = (state == G_STOP) || (state == G_WIN);

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) fsm_q <= S_IDLE;
      else      fsm_q <= fsm_d;
   end

   // Next-state logic: SET always aborts, RUN after a stop restarts the spin.
   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         S_IDLE: if (state == G_RUN) fsm_d = S_SPIN;
         S_SPIN: begin
            if (state == G_SET)  fsm_d = S_IDLE;
            else if (stop_in)    fsm_d = S_HALT;
         end
         S_HALT: begin
            if (state == G_SET)                 fsm_d = S_IDLE;
            else if (state == G_RUN)            fsm_d = S_SPIN;
            else if (halt_idx == SC_W'(LAST))   fsm_d = S_EVAL;
         end
         S_EVAL: begin
            if (state == G_SET)       fsm_d = S_IDLE;
            else if (state == G_RUN)  fsm_d = S_SPIN;
            else                      fsm_d = S_DONE;
         end
         S_DONE: begin
            if (state == G_SET)       fsm_d = S_IDLE;
            else if (state == G_RUN)  fsm_d = S_SPIN;
         end
         default: fsm_d = S_IDLE;
      endcase
   end

   // Output/control decode: which edges count, freeze, evaluate or clear.
   always_comb begin
      spin_all  = ((fsm_q == S_IDLE) || (fsm_q == S_SPIN)) && (state == G_RUN);
      halt_edge = ((fsm_q == S_SPIN) || (fsm_q == S_HALT)) && stop_in;
      restart   = ((fsm_q == S_HALT) || (fsm_q == S_EVAL) || (fsm_q == S_DONE))
                  && (state == G_RUN);
      // Edge index relative to STOP entry: 0 on the entry edge itself.
      halt_idx  = (fsm_q == S_HALT) ? stop_cnt_q + SC_W'(1) : '0;
   end

   // Datapath next values: prescalers, reel symbols, stop counter, status flags.
   always_comb begin
      logic [DIV_W-1:0] div_base;
      logic             adv;
      logic             all_eq;

      stop_cnt_d = stop_cnt_q;
      stopped_d  = stopped_q;
      win_d      = win_q;
      lose_d     = lose_q;
      div_base   = '0;
      adv        = 1'b0;
      all_eq     = 1'b1;

      for (int k = 0; k < NUM_REELS; k++) begin
         reel_d[k]    = reel_q[k];
         div_cnt_d[k] = div_cnt_q[k];
         // Entering SPIN from IDLE counts from a cleared divider on that same edge.
         div_base = (fsm_q == S_IDLE) ? '0 : div_cnt_q[k];
         // Reel 0 freezes on the STOP edge; reel k keeps going for STAGGER*k edges.
         adv = spin_all || (halt_edge && (k > 0) && (halt_idx < SC_W'(STAGGER * k)));
         if (restart) begin
            div_cnt_d[k] = '0;
         end else if (adv) begin
            if (div_base == DIV_W'(SPIN_DIV + k - 1)) begin
               reel_d[k]    = reel_q[k] + SYMBOL_W'(1);
               div_cnt_d[k] = '0;
            end else begin
               div_cnt_d[k] = div_base + DIV_W'(1);
            end
         end
         if (reel_q[k] != reel_q[0]) all_eq = 1'b0;
      end

      if ((fsm_q == S_SPIN) && stop_in)      stop_cnt_d = '0;
      else if ((fsm_q == S_HALT) && stop_in) stop_cnt_d = halt_idx;

      if ((fsm_q == S_HALT) && stop_in && (halt_idx == SC_W'(LAST))) stopped_d = 1'b1;

      if ((fsm_q == S_EVAL) && stop_in) begin
         win_d  = all_eq;
         lose_d = !all_eq;
      end

      // SET aborts and RUN restarts: either way the previous result is gone.
      if ((state == G_SET) || (state == G_RUN)) begin
         stopped_d = 1'b0;
         win_d     = 1'b0;
         lose_d    = 1'b0;
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NUM_REELS; k++) begin
            reel_q[k]    <= '0;
            div_cnt_q[k] <= '0;
         end
         stop_cnt_q <= '0;
         stopped_q  <= 1'b0;
         win_q      <= 1'b0;
         lose_q     <= 1'b0;
      end else begin
         for (int k = 0; k < NUM_REELS; k++) begin
            reel_q[k]    <= reel_d[k];
            div_cnt_q[k] <= div_cnt_d[k];
         end
         stop_cnt_q <= stop_cnt_d;
         stopped_q  <= stopped_d;
         win_q      <= win_d;
         lose_q     <= lose_d;
      end
   end

   // Pack reel symbols onto the output bus, reel i at [SYMBOL_W*i +: SYMBOL_W].
   always_comb begin
      reel_val = '0;
      for (int k = 0; k < NUM_REELS; k++) begin
         reel_val[SYMBOL_W*k +: SYMBOL_W] = reel_q[k];
      end
   end

   assign reels_stopped = stopped_q;
   assign win_flag      = win_q;
   assign lose_flag     = lose_q;

endmodule

// File: tb/tb_slot_reel_controller.sv
// Directed bench: reset, spin rates, staggered halt with lose, abort/resume, win.
module tb_slot_reel_controller;

   localparam logic [1:0] G_SET  = 2'b00;
   localparam logic [1:0] G_RUN  = 2'b01;
   localparam logic [1:0] G_STOP = 2'b10;
   localparam logic [1:0] G_WIN  = 2'b11;

   logic       clk;
   logic       rst, rst_w;
   logic [1:0] st, st_w;
   logic [8:0] reel_val, reel_val_w;
   logic       stopped, win, lose;
   logic       stopped_w, win_w, lose_w;

   int n_tests = 0;
   int n_fail  = 0;

   slot_reel_controller dut (
      .clk           (clk),
      .rst           (rst),
      .state         (st),
      .reel_val      (reel_val),
      .reels_stopped (stopped),
      .win_flag      (win),
      .lose_flag     (lose)
   );

   slot_reel_controller #(.SPIN_DIV(64)) dut_w (
      .clk           (clk),
      .rst           (rst_w),
      .state         (st_w),
      .reel_val      (reel_val_w),
      .reels_stopped (stopped_w),
      .win_flag      (win_w),
      .lose_flag     (lose_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; rst_w = 1'b0;
      st = G_RUN; st_w = G_SET;
      step(3);
      check("rst_reel",    32'(reel_val), 32'd0);
      check("rst_stopped", 32'(stopped),  32'd0);
      check("rst_win",     32'(win),      32'd0);
      check("rst_lose",    32'(lose),     32'd0);
      rst = 1'b1; rst_w = 1'b1;

      // Ten RUN edges: reel0 steps at 4,8; reel1 at 5,10; reel2 at 6.
      step(10);
      check("spin10", 32'(reel_val), 32'({3'd1, 3'd2, 3'd2}));
      // Asynchronous reset mid-cycle clears outputs before any edge.
      #3 rst = 1'b0;
      #1;
      check("async_rst_reel", 32'(reel_val), 32'd0);
      check("async_rst_win",  32'(win | lose | stopped), 32'd0);
      #1 rst = 1'b1;

      // Forty RUN edges from reset.
      step(40);
      check("spin40",  32'(reel_val), 32'({3'd6, 3'd0, 3'd2}));
      check("div0_40", 32'(dut.div_cnt_q[0]), 32'd0);
      check("div1_40", 32'(dut.div_cnt_q[1]), 32'd0);
      check("div2_40", 32'(dut.div_cnt_q[2]), 32'd4);

      // Staggered halt: edge T is the first STOP edge.
      st = G_STOP;
      step(1);
      check("T_reel0", 32'(reel_val[2:0]), 32'd2);
      step(7);   // T+7: reel1 stepped at T+4, reel2 7 at T+1 and wrapped to 0 at T+7
      check("T7_wrap", 32'(reel_val), 32'({3'd0, 3'd1, 3'd2}));
      step(8);   // T+15
      check("T15_reel",    32'(reel_val), 32'({3'd1, 3'd1, 3'd2}));
      check("T15_stopped", 32'(stopped),  32'd0);
      step(1);   // T+16
      check("T16_stopped", 32'(stopped),  32'd1);
      check("T16_lose",    32'(lose),     32'd0);
      check("T16_reel",    32'(reel_val), 32'({3'd1, 3'd1, 3'd2}));
      step(1);   // T+17
      check("T17_lose", 32'(lose), 32'd1);
      check("T17_win",  32'(win),  32'd0);
      step(3);
      check("done_hold_lose", 32'(lose), 32'd1);
      st = G_SET;
      step(1);
      check("set_clr_flags", 32'({stopped, win, lose}), 32'd0);

      // Abort: same 40-edge start, STOP for T..T+4, SET sampled at T+5.
      rst = 1'b0;
      #2 rst = 1'b1;
      st = G_RUN;
      step(40);
      st = G_STOP;
      step(5);
      st = G_SET;
      step(1);
      check("abort_reel",  32'(reel_val), 32'({3'd7, 3'd1, 3'd2}));
      check("abort_flags", 32'({stopped, win, lose}), 32'd0);
      step(3);
      check("abort_hold",  32'(reel_val), 32'({3'd7, 3'd1, 3'd2}));
      st = G_RUN;
      step(4);
      check("resume4", 32'(reel_val), 32'({3'd7, 3'd1, 3'd3}));
      step(2);
      check("resume6_wrap", 32'(reel_val), 32'({3'd0, 3'd2, 3'd3}));
      check("resume_flags", 32'({stopped, win, lose}), 32'd0);

      // Win: slow reels never step, so all stay at 0.
      st_w = G_RUN;
      step(10);
      st_w = G_STOP;
      step(16);  // T+15
      check("w_T15_stopped", 32'(stopped_w), 32'd0);
      step(1);   // T+16
      check("w_T16_stopped", 32'(stopped_w), 32'd1);
      check("w_T16_win",     32'(win_w),     32'd0);
      step(1);   // T+17
      check("w_T17_win",  32'(win_w),      32'd1);
      check("w_T17_lose", 32'(lose_w),     32'd0);
      check("w_reels",    32'(reel_val_w), 32'd0);
      st_w = G_WIN;
      step(5);
      check("w_held",     32'(win_w),     32'd1);
      check("w_held_stp", 32'(stopped_w), 32'd1);
      st_w = G_SET;
      step(1);
      check("w_set_clr", 32'({stopped_w, win_w, lose_w}), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
